// File: rtl/regfile_pkg.sv
// Shared constants and types for the bypassing register-read stage.
// Optional build macro in dependents: REGFILE_R0_ZERO_EN.
package regfile_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_RD_DEF = 2;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // The PC lives in the top entry unless the integrator places it elsewhere.
  function automatic int pc_idx_default(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by issue, cleared by writeback.
// Build macro REGFILE_R0_ZERO_EN keeps register 0 permanently not-busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PC_IDX = pc_idx_default(ADDR_W)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic                   pc_wr_en_i,
  input  logic                   sb_set_en_i,
  input  logic [ADDR_W-1:0]      sb_set_addr_i,
  output logic [2**ADDR_W-1:0]   busy_next_o
);
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [2**ADDR_W-1:0] busy_q, busy_d;

  // Set is applied last so a freshly issued writer beats a same-cycle retire.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i)    busy_d[wr_addr_i] = 1'b0;
    if (pc_wr_en_i) busy_d[PC_A]      = 1'b0;
    if (sb_set_en_i && !(R0_ZERO && sb_set_addr_i == '0))
      busy_d[sb_set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_next_o = busy_d;
endmodule

// File: rtl/regfile_bypass_rd.sv
// Pipelined register-read stage: NUM_RD ports, write-through bypass, PC port.
// Build macro REGFILE_R0_ZERO_EN makes register 0 a hard-wired zero.
module regfile_bypass_rd
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int PC_IDX = pc_idx_default(ADDR_W)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic                     rd_valid_o,
  output logic                     rd_equal_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     pc_wr_en_i,
  input  logic [DATA_W-1:0]        pc_wr_data_i,
  output logic [DATA_W-1:0]        pc_out_o,
  input  logic                     sb_set_en_i,
  input  logic [ADDR_W-1:0]        sb_set_addr_i
);
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DATA_W-1:0]        regs_d [DEPTH];
  logic [DEPTH-1:0]         busy_next;
  logic [NUM_RD*DATA_W-1:0] rd_data_d, rd_data_q;
  logic [NUM_RD-1:0]        rd_busy_d, rd_busy_q;
  logic                     rd_equal_d, rd_equal_q, rd_valid_q;

  regfile_scoreboard #(.ADDR_W(ADDR_W), .PC_IDX(PC_IDX)) u_sb (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .pc_wr_en_i   (pc_wr_en_i),
    .sb_set_en_i  (sb_set_en_i),
    .sb_set_addr_i(sb_set_addr_i),
    .busy_next_o  (busy_next)
  );

  // regs_d is the post-write register image; reading it is the bypass, and the
  // PC port is applied after the general port so it wins on a PC collision.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_i && !(R0_ZERO && wr_addr_i == '0)) regs_d[wr_addr_i] = wr_data_i;
    if (pc_wr_en_i) regs_d[PC_A] = pc_wr_data_i;
    if (R0_ZERO)    regs_d[0]    = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign rd_data_d[k*DATA_W +: DATA_W] = regs_d[rd_addr_i[k*ADDR_W +: ADDR_W]];
    assign rd_busy_d[k]                  = busy_next[rd_addr_i[k*ADDR_W +: ADDR_W]];
  end

  assign rd_equal_d = (rd_data_d[0 +: DATA_W] == rd_data_d[DATA_W +: DATA_W]);

  // Output stage holds its last result while idle; only valid drops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
      rd_equal_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_data_q  <= rd_data_d;
        rd_busy_q  <= rd_busy_d;
        rd_equal_q <= rd_equal_d;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_busy_o  = rd_busy_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_equal_o = rd_equal_q;
  assign pc_out_o   = regs_q[PC_A];
endmodule

// File: tb/tb_regfile_bypass_rd.sv
// Directed bench for regfile_bypass_rd at default parameters (PC at entry 7).
module tb_regfile_bypass_rd;
  logic        clk = 1'b0;
  logic        reset, rd_en, wr_en, pc_wr_en, sb_set_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        rd_valid, rd_equal;
  logic [2:0]  wr_addr, sb_set_addr;
  logic [15:0] wr_data, pc_wr_data, pc_out;
  int nvec = 0;
  int nerr = 0;

  regfile_bypass_rd dut (
    .clk_i(clk), .reset_i(reset), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_busy_o(rd_busy), .rd_valid_o(rd_valid),
    .rd_equal_o(rd_equal), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .pc_wr_en_i(pc_wr_en), .pc_wr_data_i(pc_wr_data),
    .pc_out_o(pc_out), .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; pc_wr_en = 0; sb_set_en = 0;
  endtask

  initial begin
    reset = 1; idle(); rd_addr = '0; wr_addr = '0; wr_data = '0;
    pc_wr_data = '0; sb_set_addr = '0;
    tick(); tick();
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data",  rd_data,       32'd0);
    chk("rst_busy",  32'(rd_busy),  32'd0);
    chk("rst_equal", 32'(rd_equal), 32'd0);
    chk("rst_pc",    32'(pc_out),   32'd0);

    reset = 0; rd_en = 1; rd_addr = {3'd0, 3'd3};
    tick(); idle();
    chk("r0_valid", 32'(rd_valid), 32'd1);
    chk("r0_data",  rd_data,       32'd0);
    chk("r0_equal", 32'(rd_equal), 32'd1);
    chk("r0_busy",  32'(rd_busy),  32'd0);

    // write r2 with a same-cycle read: bypass
    wr_en = 1; wr_addr = 3'd2; wr_data = 16'h1234; rd_en = 1; rd_addr = {3'd0, 3'd2};
    tick(); idle();
    chk("byp_data",  rd_data,       32'h0000_1234);
    chk("byp_equal", 32'(rd_equal), 32'd0);

    tick();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_hold",  rd_data,       32'h0000_1234);

    rd_en = 1; rd_addr = {3'd2, 3'd2};
    tick(); idle();
    chk("stor_data",  rd_data,       32'h1234_1234);
    chk("stor_equal", 32'(rd_equal), 32'd1);

    // PC port beats general write to PC_IDX
    pc_wr_en = 1; pc_wr_data = 16'h0040; wr_en = 1; wr_addr = 3'd7; wr_data = 16'hFFFF;
    rd_en = 1; rd_addr = {3'd2, 3'd7};
    tick(); idle();
    chk("pc_byp", rd_data, 32'h1234_0040);
    chk("pc_out", 32'(pc_out), 32'h0040);
    rd_en = 1; rd_addr = {3'd0, 3'd7};
    tick(); idle();
    chk("pc_stor", rd_data, 32'h0000_0040);

    // scoreboard
    sb_set_en = 1; sb_set_addr = 3'd5; rd_en = 1; rd_addr = {3'd3, 3'd5};
    tick(); idle();
    chk("sb_set", 32'(rd_busy), 32'b01);
    wr_en = 1; wr_addr = 3'd5; wr_data = 16'h0055; sb_set_en = 1; sb_set_addr = 3'd5;
    rd_en = 1; rd_addr = {3'd5, 3'd5};
    tick(); idle();
    chk("sb_setwin", 32'(rd_busy), 32'b11);
    chk("sb_setwin_data", rd_data, 32'h0055_0055);
    wr_en = 1; wr_addr = 3'd5; wr_data = 16'h0066; rd_en = 1; rd_addr = {3'd3, 3'd5};
    tick(); idle();
    chk("sb_clr", 32'(rd_busy), 32'b00);
    chk("sb_clr_data", rd_data, 32'h0000_0066);

    // equality flag
    wr_en = 1; wr_addr = 3'd1; wr_data = 16'hBEEF; tick();
    wr_addr = 3'd4; tick(); idle();
    rd_en = 1; rd_addr = {3'd4, 3'd1};
    tick(); idle();
    chk("eq_true", 32'(rd_equal), 32'd1);
    chk("eq_data", rd_data, 32'hBEEF_BEEF);
    wr_en = 1; wr_addr = 3'd4; wr_data = 16'hBEEE; rd_en = 1; rd_addr = {3'd4, 3'd1};
    tick(); idle();
    chk("eq_false", 32'(rd_equal), 32'd0);
    chk("eq_false_data", rd_data, 32'hBEEE_BEEF);

    // set beats PC-port clear; then PC write alone retires it
    sb_set_en = 1; sb_set_addr = 3'd7; pc_wr_en = 1; pc_wr_data = 16'h0100;
    rd_en = 1; rd_addr = {3'd0, 3'd7};
    tick(); idle();
    chk("pc_sb_set", 32'(rd_busy), 32'b01);
    chk("pc_sb_data", rd_data, 32'h0000_0100);
    pc_wr_en = 1; pc_wr_data = 16'h0102; rd_en = 1; rd_addr = {3'd0, 3'd7};
    tick(); idle();
    chk("pc_sb_clr", 32'(rd_busy), 32'b00);
    chk("pc_out2", 32'(pc_out), 32'h0102);

    // register 0 behaviour
    wr_en = 1; wr_addr = 3'd0; wr_data = 16'hAAAA; sb_set_en = 1; sb_set_addr = 3'd0;
    rd_en = 1; rd_addr = {3'd4, 3'd0};
    tick(); idle();
`ifdef REGFILE_R0_ZERO_EN
    chk("r0z_data", rd_data, 32'hBEEE_0000);
    chk("r0z_busy", 32'(rd_busy), 32'b00);
`else
    chk("r0_wr_data", rd_data, 32'hBEEE_AAAA);
    chk("r0_wr_busy", 32'(rd_busy), 32'b01);
`endif

    // reset during a read drops it
    reset = 1; rd_en = 1; rd_addr = {3'd4, 3'd1};
    tick();
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_data",  rd_data,       32'd0);
    chk("mid_rst_pc",    32'(pc_out),   32'd0);
    reset = 0; rd_en = 1; rd_addr = {3'd4, 3'd1};
    tick(); idle();
    chk("post_rst_data", rd_data, 32'd0);
    chk("post_rst_valid", 32'(rd_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
